// File: rtl/ram_master.sv
// ram_master: circular sample history over an external registered-read RAM; RAM_MASTER_CLEAR_EN adds a zeroing sweep after reset
module ram_master #(
  parameter int BREITE = 8,
  parameter int TIEFE  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  input  logic [BREITE-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_rd_req,
  input  logic [TIEFE-1:0]  i_rd_ofs,
  output logic              o_rd_ready,
  output logic              o_rd_valid,
  output logic [BREITE-1:0] o_rd_data,
  output logic [TIEFE-1:0]  o_ram_addr,
  output logic              o_ram_rw,
  output logic              o_ram_write,
  output logic [BREITE-1:0] o_ram_data,
  input  logic [BREITE-1:0] i_ram_data,
  output logic [TIEFE:0]    o_count,
  output logic              o_full
);
`ifdef RAM_MASTER_CLEAR_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, CLEAR} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE} state_t;
`endif
  state_t              state_q;
  logic [TIEFE-1:0]    wr_ptr_q, addr_q;
  logic [TIEFE:0]      count_q;
  logic [BREITE-1:0]   rd_data_q, data_q;
  logic                rd_valid_q, rw_q, write_q, ready_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rw_q       <= 1'b1;
`ifdef RAM_MASTER_CLEAR_EN
      state_q    <= CLEAR;
      write_q    <= 1'b1;
      ready_q    <= 1'b0;
`else
      state_q    <= IDLE;
      write_q    <= 1'b0;
      ready_q    <= 1'b1;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // reads win; a concurrent write simply stays pending
          if (i_rd_req) begin
            state_q <= READ;
            addr_q  <= wr_ptr_q - TIEFE'(1) - i_rd_ofs;
            rw_q    <= 1'b0;
            ready_q <= 1'b0;
          end else if (i_wr_valid) begin
            state_q <= WRITE;
            addr_q  <= wr_ptr_q;
            data_q  <= i_wr_data;
            write_q <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        WRITE: begin
          state_q  <= IDLE;
          write_q  <= 1'b0;
          ready_q  <= 1'b1;
          wr_ptr_q <= wr_ptr_q + TIEFE'(1);
          count_q  <= count_q + {{TIEFE{1'b0}}, ~count_q[TIEFE]};
        end
        READ: state_q <= CAPTURE;
        CAPTURE: begin
          state_q    <= IDLE;
          rd_data_q  <= i_ram_data;
          rd_valid_q <= 1'b1;
          rw_q       <= 1'b1;
          ready_q    <= 1'b1;
        end
`ifdef RAM_MASTER_CLEAR_EN
        CLEAR: begin
          addr_q <= addr_q + TIEFE'(1);
          if (&addr_q) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_wr_ready  = ready_q;
  assign o_rd_ready  = ready_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_rw    = rw_q;
  // a write in flight must not reach the RAM on the reset edge
  assign o_ram_write = write_q & ~i_rst;
  assign o_ram_data  = data_q;
  assign o_count     = count_q;
  assign o_full      = count_q[TIEFE];
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: table-driven history buffer checks with a read-data scoreboard and a registered RAM model
module tb_ram_master;
  localparam int W = 8, T = 2, D = 1 << T;
  logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, rd_req = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [T-1:0] rd_ofs = '0;
  logic wr_ready, rd_ready, rd_valid, ram_rw, ram_write, full;
  logic [W-1:0] rd_data, ram_data, ram_q;
  logic [T-1:0] ram_addr;
  logic [T:0] count;
  ram_master #(.BREITE(W), .TIEFE(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_rd_req(rd_req), .i_rd_ofs(rd_ofs), .o_rd_ready(rd_ready), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_ram_addr(ram_addr), .o_ram_rw(ram_rw), .o_ram_write(ram_write), .o_ram_data(ram_data),
    .i_ram_data(ram_q), .o_count(count), .o_full(full));
  always #5 clk = ~clk;
  logic [W-1:0] mem [D];
  bit ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) for (int i = 0; i < D; i++) mem[i] <= W'(8'hE0 + i);
    else if (ram_rw && ram_write) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end
  int total = 0, bad = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] mm [D];
  logic [W-1:0] mon_e;
  logic [T-1:0] mptr;
  int mcount;
  always @(negedge clk) if (rd_valid) begin
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected: rd_valid with data %0h, none expected", rd_data);
    end else begin
      mon_e = sb.pop_front();
      if (rd_data !== mon_e) begin
        bad++;
        $display("FAIL sb_data: got %0h want %0h", rd_data, mon_e);
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; rd_req = 1'b0;
    #1 chk("rst_cycle_write", ram_write, 0);
    step();
    ram_init = 1'b0;
    chk("rst_count", count, 0); chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
    chk("rst_addr", ram_addr, 0); chk("rst_data", ram_data, 0);
    chk("rst_rw", ram_rw, 1); chk("rst_write", ram_write, 0);
    rst = 1'b0;
`ifdef RAM_MASTER_CLEAR_EN
    for (int i = 0; i < D; i++) begin
      chk("clr_write", ram_write, 1); chk("clr_addr", ram_addr, i);
      chk("clr_data", ram_data, 0); chk("clr_rw", ram_rw, 1);
      chk("clr_ready", {wr_ready, rd_ready}, 0);
      mm[i] = '0;
      step();
    end
`endif
    #0 chk("idle_ready", {wr_ready, rd_ready}, 2'b11);
    chk("idle_write", ram_write, 0);
    mptr = '0; mcount = 0;
  endtask
  task automatic do_write(input logic [W-1:0] d);
    wr_valid = 1'b1; wr_data = d;
    chk("wr_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    chk("wr_ram_write", ram_write, 1); chk("wr_ram_rw", ram_rw, 1);
    chk("wr_ram_addr", ram_addr, mptr); chk("wr_ram_data", ram_data, d);
    chk("wr_busy", {wr_ready, rd_ready}, 0);
    mm[mptr] = d; mptr = mptr + 1'b1;
    if (mcount < D) mcount++;
    step();
    chk("wr_count", count, mcount); chk("wr_full", full, mcount == D);
    chk("wr_back_idle", wr_ready, 1); chk("wr_write_off", ram_write, 0);
  endtask
  task automatic do_read(input logic [T-1:0] ofs, input logic [W-1:0] exp);
    logic [T-1:0] a;
    a = mptr - 1'b1 - ofs;
    rd_req = 1'b1; rd_ofs = ofs;
    chk("rd_ready", rd_ready, 1);
    sb.push_back(exp);
    step();
    rd_req = 1'b0;
    chk("rd_rw", ram_rw, 0); chk("rd_write", ram_write, 0);
    chk("rd_addr", ram_addr, a); chk("rd_busy", {wr_ready, rd_ready}, 0);
    chk("rd_valid_e1", rd_valid, 0);
    step();
    chk("cap_rw", ram_rw, 0); chk("cap_addr", ram_addr, a); chk("rd_valid_e2", rd_valid, 0);
    step();
    chk("rd_valid_e3", rd_valid, 1);
    step();
    chk("rd_valid_drop", rd_valid, 0); chk("rd_hold", rd_data, exp);
    chk("rd_back_idle", rd_ready, 1);
  endtask
  typedef struct {bit rd; logic [W-1:0] d; logic [T-1:0] ofs; logic [W-1:0] exp; int cnt;} vec_t;
  vec_t tv [13];
  initial begin
    logic [T-1:0] a;
    logic [W-1:0] old;
    for (int i = 0; i < D; i++) mm[i] = W'(8'hE0 + i);
    tv[0]  = '{0, 8'h11, 0, 0, 1};
    tv[1]  = '{0, 8'h22, 0, 0, 2};
    tv[2]  = '{0, 8'h33, 0, 0, 3};
    tv[3]  = '{1, 0, 0, 8'h33, 3};
    tv[4]  = '{1, 0, 2, 8'h11, 3};
    tv[5]  = '{1, 0, 1, 8'h22, 3};
    tv[6]  = '{0, 8'h44, 0, 0, 4};
    tv[7]  = '{0, 8'h55, 0, 0, 4};
    tv[8]  = '{1, 0, 0, 8'h55, 4};
    tv[9]  = '{1, 0, 3, 8'h22, 4};
    tv[10] = '{1, 0, 1, 8'h44, 4};
    tv[11] = '{0, 8'h66, 0, 0, 4};
    tv[12] = '{1, 0, 3, 8'h33, 4};
    do_reset();
    do_read(3, mm[0]);
    for (int i = 0; i < 13; i++) begin
      if (tv[i].rd) do_read(tv[i].ofs, tv[i].exp);
      else do_write(tv[i].d);
      chk("tbl_count", count, tv[i].cnt);
    end
    // simultaneous read and write: read first, write stays pending
    rd_req = 1'b1; rd_ofs = 0; wr_valid = 1'b1; wr_data = 8'h77;
    chk("both_ready", {wr_ready, rd_ready}, 2'b11);
    sb.push_back(mm[mptr - 1'b1]);
    step();
    rd_req = 1'b0;
    chk("both_rd_first", ram_rw, 0); chk("both_wr_blocked", wr_ready, 0); chk("both_no_write", ram_write, 0);
    step();
    chk("both_wr_blocked2", wr_ready, 0);
    step();
    chk("both_rd_valid", rd_valid, 1); chk("both_wr_ready", wr_ready, 1); chk("both_count", count, mcount);
    step();
    wr_valid = 1'b0;
    chk("both_wr_write", ram_write, 1); chk("both_wr_data", ram_data, 8'h77); chk("both_wr_addr", ram_addr, mptr);
    mm[mptr] = 8'h77; mptr = mptr + 1'b1;
    step();
    chk("both_count2", count, mcount);
    do_read(0, 8'h77);
    // reset while a write is in flight
    wr_valid = 1'b1; wr_data = 8'hAA;
    step();
    wr_valid = 1'b0;
    chk("abort_in_write", ram_write, 1);
    a = mptr; old = mem[a];
    rst = 1'b1;
    #1 chk("abort_gate", ram_write, 0);
    step();
    chk("abort_mem", mem[a], old); chk("abort_count", count, 0); chk("abort_addr", ram_addr, 0);
    do_reset();
    do_write(8'h5A);
    do_read(0, 8'h5A);
    do_read(1, mm[D-1]);
    // reset during CAPTURE must swallow the result
    rd_req = 1'b1; rd_ofs = 0;
    step();
    rd_req = 1'b0;
    step();
    do_reset();
    chk("abort_rd_valid", rd_valid, 0);
    step();
    chk("abort_rd_valid2", rd_valid, 0);
    step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
